// File: rtl/biu_pkg.sv
// biu_pkg: types and bus encoding shared by the BIU master and slave.
package biu_pkg;

  // Bit positions inside the two-bit bus control field.
  localparam int unsigned BUS_CTRL_RNW = 1;
  localparam int unsigned BUS_CTRL_DV  = 0;

  // One-hot master FSM states.
  typedef enum logic [3:0] {
    StIdle    = 4'b0001,
    StWaitGnt = 4'b0010,
    StSendReq = 4'b0100,
    StWaitRsp = 4'b1000
  } biu_master_state_t;

endpackage

// File: rtl/biu_master_if.sv
// biu_master_if: local initiator side of the BIU master.
interface biu_master_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  en;
  logic                  rnw;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_out;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_valid;
  logic                  busy;
  logic                  error;

  modport biu (
    input  en, rnw, address, data_out,
    output data_in, data_valid, busy, error
  );

  modport initiator (
    output en, rnw, address, data_out,
    input  data_in, data_valid, busy, error
  );
endinterface

// File: rtl/biu_master_timer.sv
// biu_master_timer: counts cycles since the last clear; o_expire marks the TIMEOUT_CYCLES-th
// cycle after clear was released (count 0 is the first uncleared cycle).
module biu_master_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic n_rst,
  input  logic i_clear,
  output logic o_expire
);
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] r_count;

  assign o_expire = !i_clear && (r_count == LastCnt);

  // Cycle counter: held at zero while cleared, saturates at the expiry value.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (!o_expire) begin
      r_count <= r_count + 1'b1;
    end
  end
endmodule

// File: rtl/biu_master.sv
// biu_master: turns one local request into a single bus beat and returns read data plus a
// one-cycle completion pulse. One transaction outstanding; arbitration via o_bus_req/i_bus_gnt.
// The shared bus is carried as three tri-state nets: address, data and control
// (control[1]=rnw, control[0]=data_valid).
// Build option: define BIU_MASTER_TIMEOUT_EN to bound the read-response wait to TIMEOUT_CYCLES.
module biu_master
  import biu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  n_rst,
  inout  wire  [ADDR_WIDTH-1:0] bus_address,
  inout  wire  [DATA_WIDTH-1:0] bus_data,
  inout  wire  [1:0]            bus_control,
  output logic                  o_bus_req,
  input  logic                  i_bus_gnt,
  biu_master_if.biu             biu
);

  biu_master_state_t r_state, w_state_next;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rnw;
  logic                  r_valid;

  logic       w_accept;
  logic       w_response;
  logic       w_expire;
  logic       w_capture;
  logic       w_timeout;
  logic       w_drive;
  logic       w_in_rsp;
  logic [1:0] w_ctrl;

  // A response is a valid read beat carrying our own address; anything else is ignored.
  assign w_response = bus_control[BUS_CTRL_DV] & bus_control[BUS_CTRL_RNW] &
                      (bus_address == r_addr);
  assign w_in_rsp   = (r_state == StWaitRsp);

`ifdef BIU_MASTER_TIMEOUT_EN
  logic r_error;

  biu_master_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .n_rst   (n_rst),
    .i_clear (!w_in_rsp),
    .o_expire(w_expire)
  );

  // Error flag accompanies the completion pulse of a timed-out read only.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_error <= 1'b0;
    end else begin
      r_error <= w_timeout;
    end
  end

  assign biu.error = r_error;
`else
  assign w_expire  = 1'b0;
  assign biu.error = 1'b0;
`endif

  // Next-state logic; a response in the expiry cycle takes priority over the timeout.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_timeout    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (biu.en) begin
          w_accept     = 1'b1;
          w_state_next = StWaitGnt;
        end
      end
      StWaitGnt: begin
        if (i_bus_gnt) w_state_next = StSendReq;
      end
      StSendReq: begin
        w_state_next = r_rnw ? StWaitRsp : StIdle;
      end
      StWaitRsp: begin
        if (w_response) begin
          w_capture    = 1'b1;
          w_state_next = StIdle;
        end else if (w_expire) begin
          w_timeout    = 1'b1;
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Request latch, loaded only when a request is accepted in IDLE.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_rnw   <= 1'b0;
    end else if (w_accept) begin
      r_addr  <= biu.address;
      r_wdata <= biu.data_out;
      r_rnw   <= biu.rnw;
    end
  end

  // Completion pulse and read data; data_in holds until the next read completes.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_valid <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_valid <= ((r_state == StSendReq) && !r_rnw) || w_capture || w_timeout;
      if (w_capture) begin
        r_rdata <= bus_data;
      end else if (w_timeout) begin
        r_rdata <= '1;
      end
    end
  end

  // Control field of the outgoing beat.
  always_comb begin
    w_ctrl               = '0;
    w_ctrl[BUS_CTRL_RNW] = r_rnw;
    w_ctrl[BUS_CTRL_DV]  = 1'b1;
  end

  // The master owns the bus only during the single SEND_REQ cycle.
  assign w_drive     = (r_state == StSendReq);
  assign bus_address = w_drive ? r_addr  : 'z;
  assign bus_data    = w_drive ? r_wdata : 'z;
  assign bus_control = w_drive ? w_ctrl  : 'z;

  assign o_bus_req      = (r_state != StIdle);
  assign biu.busy       = (r_state != StIdle);
  assign biu.data_valid = r_valid;
  assign biu.data_in    = r_rdata;

endmodule

// File: tb/tb_biu_master.sv
// tb_biu_master: drives biu_master against a behavioural memory-mapped slave (0x1000..0x10FF)
// and checks every completion against a transaction-level expectation.
`timescale 1ns/1ps
module tb_biu_master;
  import biu_pkg::*;

  localparam int unsigned TCyc = 8;

  logic clk       = 1'b0;
  logic n_rst     = 1'b0;
  logic i_bus_gnt = 1'b0;
  logic o_bus_req;

  wire [31:0] bus_address;
  wire [31:0] bus_data;
  wire [1:0]  bus_control;

  int checks = 0;
  int errors = 0;

  biu_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) u_if ();

  biu_master #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(TCyc)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .bus_address(bus_address),
    .bus_data   (bus_data),
    .bus_control(bus_control),
    .o_bus_req  (o_bus_req),
    .i_bus_gnt  (i_bus_gnt),
    .biu        (u_if)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural slave ----------------
  logic        s_drv = 1'b0;
  logic [31:0] s_addr = '0;
  logic [31:0] s_data = '0;
  logic [1:0]  s_ctrl = '0;
  logic [31:0] slv_mem [64];
  int          slv_lat = 2;
  int          rsp_cnt = -1;
  logic [31:0] rsp_addr, rsp_data;
  bit          rsp_decoy, decoy_kind;
  int          beats = 0;

  assign bus_address = s_drv ? s_addr : 'z;
  assign bus_data    = s_drv ? s_data : 'z;
  assign bus_control = s_drv ? s_ctrl : 'z;

  // Watches the bus mid-cycle; answers mapped reads slv_lat cycles after the request beat,
  // optionally preceded by a decoy beat (wrong address or dv=0) one cycle earlier.
  always @(negedge clk) begin
    logic        prev_drv;
    logic [1:0]  c;
    logic [31:0] a, d;
    prev_drv = s_drv;
    c = bus_control;
    a = bus_address;
    d = bus_data;
    s_drv = 1'b0;
    if (!n_rst) begin
      rsp_cnt = -1;
    end else if (rsp_cnt > 0) begin
      rsp_cnt = rsp_cnt - 1;
      if (rsp_cnt == 0) begin
        s_drv = 1'b1; s_addr = rsp_addr; s_data = rsp_data; s_ctrl = 2'b11;
        rsp_cnt = -1;
      end else if (rsp_cnt == 1 && rsp_decoy) begin
        s_drv  = 1'b1;
        s_data = ~rsp_data;
        if (decoy_kind) begin s_addr = rsp_addr ^ 32'h4; s_ctrl = 2'b11; end
        else begin s_addr = rsp_addr; s_ctrl = 2'b10; end
      end
    end else if (!prev_drv && c[BUS_CTRL_DV] === 1'b1) begin
      beats++;
      if (a >= 32'h1000 && a < 32'h1100) begin
        if (c[BUS_CTRL_RNW] === 1'b1) begin
          rsp_cnt    = slv_lat;
          rsp_addr   = a;
          rsp_data   = slv_mem[a[7:2]];
          rsp_decoy  = 1'($urandom_range(0, 1));
          decoy_kind = 1'($urandom_range(0, 1));
        end else begin
          slv_mem[a[7:2]] = d;
        end
      end
    end
  end

  // ---------------- reference model and checks ----------------
  logic [31:0] ref_mem [64];
  logic [31:0] exp_rdata = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // The master must not present a valid beat here (released bus reads z or 0).
  task automatic chk_quiet(input string tag);
    chk(tag, {31'd0, (bus_control[BUS_CTRL_DV] === 1'b1)}, 32'd0);
  endtask

  task automatic idle(input int cyc);
    for (int i = 0; i < cyc; i++) begin
      @(posedge clk); #1;
      chk("idle_valid", u_if.data_valid, 0);
      chk("idle_busy", u_if.busy, 0);
      chk("idle_req", o_bus_req, 0);
      chk_quiet("idle_bus");
    end
  endtask

  // Issues one request from the current cycle; returns in the completion-pulse cycle.
  // Completion expected 2 + grant delay + (slave latency | timeout | 0) cycles after the
  // sampling edge of en.
  task automatic txn(input bit rnw, input logic [31:0] addr, input logic [31:0] wdata,
                     input int lat, input int gdly, input bit poke, input bit to);
    int n, extra, b0;
    logic [5:0] idx;
    idx = addr[7:2];
    b0 = beats;
    slv_lat = lat;
    if (gdly > 0) i_bus_gnt = 1'b0;
    u_if.en = 1'b1; u_if.rnw = rnw; u_if.address = addr; u_if.data_out = wdata;
    @(posedge clk); #1;
    u_if.en = 1'b0;
    chk("busy_after_en", u_if.busy, 1);
    chk("valid_after_en", u_if.data_valid, 0);
    extra = to ? int'(TCyc) : (rnw ? lat : 0);
    n = 0;
    while (u_if.data_valid !== 1'b1 && n < 2 + gdly + extra + 16) begin
      if (n == gdly) i_bus_gnt = 1'b1;
      if (n < gdly) begin
        chk("req_wait_gnt", o_bus_req, 1);
        chk_quiet("bus_wait_gnt");
      end
      if (poke && n == 0) begin
        u_if.en = 1'b1; u_if.address = addr ^ 32'h40; u_if.rnw = ~rnw; u_if.data_out = ~wdata;
      end
      if (poke && n == 1) u_if.en = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, 2 + gdly + extra);
    chk("busy_at_done", u_if.busy, 0);
    chk("req_at_done", o_bus_req, 0);
    chk("beat_count", beats - b0, 1);
    if (to) exp_rdata = '1;
    else if (rnw) exp_rdata = ref_mem[idx];
    else begin
      ref_mem[idx] = wdata;
      chk("slave_mem", slv_mem[idx], wdata);
    end
    chk("data_in", u_if.data_in, exp_rdata);
    chk("error", u_if.error, {31'd0, to});
  endtask

  // Starts a read and applies reset k cycles after en was sampled (1=SEND_REQ, 2=WAIT_RSP).
  task automatic reset_mid(input int k);
    slv_lat = 5;
    i_bus_gnt = 1'b1;
    u_if.en = 1'b1; u_if.rnw = 1'b1; u_if.address = 32'h1008;
    @(posedge clk); #1;
    u_if.en = 1'b0;
    repeat (k) begin @(posedge clk); #1; end
    if (k == 1) begin
      chk("send_ctrl", bus_control, 2'b11);
      chk("send_addr", bus_address, 32'h1008);
    end
    n_rst = 1'b0;
    #1;
    chk("rst_busy", u_if.busy, 0);
    chk("rst_req", o_bus_req, 0);
    chk_quiet("rst_bus");
    chk("rst_valid", u_if.data_valid, 0);
    chk("rst_data_in", u_if.data_in, 0);
    chk("rst_error", u_if.error, 0);
    exp_rdata = '0;
    @(posedge clk); #2;
    n_rst = 1'b1;
    idle(8);
  endtask

  bit          rr, ch;
  int          ri, gd, lt;
  logic [31:0] wd;

  initial begin
    u_if.en = 1'b0; u_if.rnw = 1'b0; u_if.address = '0; u_if.data_out = '0;
    for (int i = 0; i < 64; i++) begin
      wd = $urandom;
      slv_mem[i] = wd;
      ref_mem[i] = wd;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", u_if.busy, 0);
    chk("reset_valid", u_if.data_valid, 0);
    chk("reset_error", u_if.error, 0);
    chk("reset_data_in", u_if.data_in, 0);
    chk("reset_req", o_bus_req, 0);
    chk_quiet("reset_bus");
    #1;
    n_rst = 1'b1;
    i_bus_gnt = 1'b1;
    idle(2);

    txn(1'b0, 32'h1004, 32'hDEADBEEF, 2, 0, 1'b0, 1'b0);
    idle(2);
    txn(1'b1, 32'h1004, 32'h0, 2, 0, 1'b0, 1'b0);
    idle(2);
    txn(1'b0, 32'h1010, 32'h12345678, 2, 10, 1'b0, 1'b0);
    txn(1'b1, 32'h1010, 32'h0, 3, 10, 1'b0, 1'b0);
    idle(1);
    txn(1'b1, 32'h1004, 32'h0, 4, 0, 1'b1, 1'b0);
    txn(1'b0, 32'h1020, 32'hA5A5_0F0F, 2, 0, 1'b1, 1'b0);
    txn(1'b1, 32'h1020, 32'h0, 2, 0, 1'b0, 1'b0);
    idle(2);

    reset_mid(1);
    reset_mid(2);

`ifdef BIU_MASTER_TIMEOUT_EN
    txn(1'b1, 32'h2000, 32'h0, 2, 0, 1'b0, 1'b1);
    idle(2);
    txn(1'b1, 32'h1004, 32'h0, int'(TCyc), 0, 1'b0, 1'b0);
    idle(2);
`endif

    for (int t = 0; t < 60; t++) begin
      rr = 1'($urandom_range(0, 1));
      ri = int'($urandom_range(0, 15));
      wd = $urandom;
      lt = int'($urandom_range(2, 5));
      gd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      ch = 1'($urandom_range(0, 1));
      txn(rr, 32'h1000 + 32'(ri * 4), wd, lt, gd, 1'($urandom_range(0, 1)), 1'b0);
      if (!ch) idle(int'($urandom_range(1, 3)));
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
